adc_spi_master: RTL and testbench

Byte-level SPI master that executes the single-byte transfer requests issued by the command processor for ADC register access. It accepts one byte per `i_tx_dv` pulse when `o_tx_ready` is high, shifts it MSB-first on MOSI while sampling MISO, and returns the received byte with a one-cycle `o_rx_dv` pulse. Chip select stays outside this block: the command processor frames multi-byte transactions with its own `spicsadc`.

---
 rtl/adc_spi_master_pkg.sv | 23 ++
 rtl/adc_spi_master_if.sv | 19 +
 rtl/adc_spi_master_edge_gen.sv | 49 ++++
 rtl/adc_spi_master.sv | 117 +++++++++++
 tb/tb_adc_spi_master.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_master_pkg.sv
// Shared definitions for the ADC SPI master: SPI mode encodings, FSM states
// and the default SCLK half-period.
package adc_spi_pkg;

  // SPI mode encodings as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEFAULT_CLKS_PER_HALF_BIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] spi_mode(input int cpol, input int cpha);
    return {cpol[0], cpha[0]};
  endfunction

endpackage

// File: rtl/adc_spi_master_if.sv
// Byte-transfer handshake between the command processor (master) and the
// SPI engine (slave).
interface adc_spi_if;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;

  modport master (
    output i_tx_byte, i_tx_dv,
    input  o_tx_ready, o_rx_byte, o_rx_dv
  );

  modport slave (
    input  i_tx_byte, i_tx_dv,
    output o_tx_ready, o_rx_byte, o_rx_dv
  );
endinterface

// File: rtl/adc_spi_master_edge_gen.sv
// SCLK generator: half-bit counter, SCLK toggle, edge strobes and edge count.
// Strobes are combinational and fire in the cycle whose clk edge produces the
// SCLK transition, so the consumer acts on that same clk edge.
module spi_edge_gen #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int CPOL = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  output logic       spi_clk,
  output logic       leading_edge,
  output logic       trailing_edge,
  output logic [4:0] edge_cnt
);

  localparam int CW = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] half_cnt;
  logic          edge_now;

  assign edge_now      = en && (half_cnt == HALF_LAST);
  assign leading_edge  = edge_now && !edge_cnt[0];
  assign trailing_edge = edge_now && edge_cnt[0];

  // Half-bit timing, SCLK toggling and edge counting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      spi_clk  <= 1'(CPOL);
    end else if (clr) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      spi_clk  <= 1'(CPOL);
    end else if (en) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        edge_cnt <= edge_cnt + 5'd1;
        spi_clk  <= ~spi_clk;
      end else begin
        half_cnt <= half_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Byte-level SPI master for ADC register access. One byte per accepted
// request, MSB first, received byte returned with a one-cycle valid pulse.
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT,
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic     clk,
  input  logic     rstn,
  adc_spi_if.slave bus,
  output logic     o_spi_clk,
  output logic     o_spi_mosi,
  input  logic     i_spi_miso
);

  localparam logic [1:0] MODE = spi_mode(CPOL, CPHA);
  localparam bit SAMPLE_TRAILING = (MODE == MODE1) || (MODE == MODE3);

  if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
    $error("adc_spi_master: CLKS_PER_HALF_BIT must be at least 2");
  end

  state_t     state, state_nxt;
  logic       started;
  logic       tx_ready_q;
  logic       rx_dv_q;
  logic [7:0] rx_byte_q;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       leading_edge, trailing_edge;
  logic [4:0] edge_cnt;
  logic       accept, shift_evt, sample_evt, gen_en, gen_clr;

  assign accept = bus.i_tx_dv && tx_ready_q;

  // The first SHIFT cycle only presents MOSI; the SCLK counter starts one
  // cycle later so that edge k lands at clk edge 1+k*H after acceptance.
  assign gen_en  = (state == SHIFT) && started && (edge_cnt != 5'd16);
  assign gen_clr = (state != SHIFT);

  // CPHA=0 shifts on trailing edges 2..14 (bit 7 preloaded at acceptance);
  // CPHA=1 shifts on every leading edge.
  assign shift_evt  = SAMPLE_TRAILING ? leading_edge
                                      : (trailing_edge && (edge_cnt != 5'd15));
  assign sample_evt = SAMPLE_TRAILING ? trailing_edge : leading_edge;

  spi_edge_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .CPOL(CPOL)
  ) u_edge_gen (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (gen_clr),
    .en           (gen_en),
    .spi_clk      (o_spi_clk),
    .leading_edge (leading_edge),
    .trailing_edge(trailing_edge),
    .edge_cnt     (edge_cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (edge_cnt == 5'd16) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, MOSI and the registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started    <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_spi_mosi <= 1'b0;
    end else begin
      started    <= (state == SHIFT);
      tx_ready_q <= (state_nxt != SHIFT);
      rx_dv_q    <= 1'b0;
      if (accept) begin
        if (SAMPLE_TRAILING) begin
          tx_sr <= bus.i_tx_byte;
        end else begin
          o_spi_mosi <= bus.i_tx_byte[7];
          tx_sr      <= {bus.i_tx_byte[6:0], 1'b0};
        end
      end else if (shift_evt) begin
        o_spi_mosi <= tx_sr[7];
        tx_sr      <= {tx_sr[6:0], 1'b0};
      end
      if (sample_evt) rx_sr <= {rx_sr[6:0], i_spi_miso};
      if ((state == SHIFT) && (state_nxt == DONE)) begin
        rx_byte_q <= rx_sr;
        rx_dv_q   <= 1'b1;
      end
    end
  end

  assign bus.o_tx_ready = tx_ready_q;
  assign bus.o_rx_dv    = rx_dv_q;
  assign bus.o_rx_byte  = rx_byte_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Self-checking bench for adc_spi_master: mode 0 / H=2 and mode 3 / H=3
// instances, behavioural SPI slaves and a scoreboard of expected rx bytes.
module tb_adc_spi_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  adc_spi_if bus0();
  adc_spi_if bus1();

  logic sclk0, mosi0, miso0;
  logic sclk1, mosi1, miso1;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int dv0_cnt = 0, dv1_cnt = 0;
  int rise0 = 0, rise1 = 0;
  logic [7:0] cap0 = '0, cap1 = '0;

  logic       loop0 = 1'b1;
  logic [7:0] slave_sr0 = '0;
  logic [7:0] pat1 = '0;
  int         idx1 = 0;
  logic       miso1_q = 1'b0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  assign miso0 = loop0 ? mosi0 : slave_sr0[7];
  assign miso1 = miso1_q;

  adc_spi_master #(.CLKS_PER_HALF_BIT(2), .CPOL(0), .CPHA(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0),
    .o_spi_clk(sclk0), .o_spi_mosi(mosi0), .i_spi_miso(miso0)
  );

  adc_spi_master #(.CLKS_PER_HALF_BIT(3), .CPOL(1), .CPHA(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .o_spi_clk(sclk1), .o_spi_mosi(mosi1), .i_spi_miso(miso1)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus0.o_rx_dv === 1'b1) dv0_cnt <= dv0_cnt + 1;
    if (bus1.o_rx_dv === 1'b1) dv1_cnt <= dv1_cnt + 1;
  end

  // Mode 0 slave: shift out on falling SCLK; MOSI captured on rising SCLK
  always @(negedge sclk0) slave_sr0 = {slave_sr0[6:0], 1'b0};
  always @(posedge sclk0) begin
    cap0 = {cap0[6:0], mosi0};
    rise0++;
  end

  // Mode 3 slave: next bit presented on falling SCLK; MOSI captured on rising
  always @(negedge sclk1) begin
    if (idx1 < 8) begin
      miso1_q = pat1[3'(7 - idx1)];
      idx1++;
    end
  end
  always @(posedge sclk1) begin
    cap1 = {cap1[6:0], mosi1};
    rise1++;
  end

  task automatic wait_ready0(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus0.o_tx_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready1(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus1.o_tx_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rx0(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus0.o_rx_dv === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Called at a negedge with ready high; returns at the negedge after acceptance
  task automatic send0(input logic [7:0] b, output int acc);
    bus0.i_tx_byte = b;
    bus0.i_tx_dv   = 1'b1;
    @(negedge clk);
    bus0.i_tx_dv   = 1'b0;
    acc = cyc;
  endtask

  task automatic send1(input logic [7:0] b, output int acc);
    bus1.i_tx_byte = b;
    bus1.i_tx_dv   = 1'b1;
    @(negedge clk);
    bus1.i_tx_dv   = 1'b0;
    acc = cyc;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus0.o_tx_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0: actual=%b required=0", bus0.o_tx_ready); end
    checks++; if (bus0.o_rx_dv !== 1'b0) begin failures++; $display("FAIL rst_rx_dv0: actual=%b required=0", bus0.o_rx_dv); end
    checks++; if (bus0.o_rx_byte !== 8'h00) begin failures++; $display("FAIL rst_rx_byte0: actual=%h required=00", bus0.o_rx_byte); end
    checks++; if (sclk0 !== 1'b0) begin failures++; $display("FAIL rst_sclk0: actual=%b required=0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin failures++; $display("FAIL rst_mosi0: actual=%b required=0", mosi0); end
    checks++; if (sclk1 !== 1'b1) begin failures++; $display("FAIL rst_sclk1_cpol: actual=%b required=1", sclk1); end
    checks++; if (bus1.o_tx_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1: actual=%b required=0", bus1.o_tx_ready); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus0.o_tx_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready0: actual=%b required=1", bus0.o_tx_ready); end
    checks++; if (bus1.o_tx_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready1: actual=%b required=1", bus1.o_tx_ready); end
  endtask

  task automatic test_loopback();
    bit ok;
    int acc, lat, r0, d0;
    logic [7:0] exp;
    loop0 = 1'b1;
    wait_ready0(50, ok);
    r0 = rise0; d0 = dv0_cnt;
    sb0.push_back(8'hA5);
    send0(8'hA5, acc);
    checks++; if (bus0.o_tx_ready !== 1'b0) begin failures++; $display("FAIL lb_ready_drop: actual=%b required=0", bus0.o_tx_ready); end
    wait_ready0(100, ok);
    lat = cyc - acc;
    checks++; if (!ok || lat != 34) begin failures++; $display("FAIL lb_latency: actual=%0d required=34 (ok=%0b)", lat, ok); end
    checks++; if (bus0.o_rx_dv !== 1'b1) begin failures++; $display("FAIL lb_rx_dv: actual=%b required=1", bus0.o_rx_dv); end
    exp = sb0.pop_front();
    checks++; if (bus0.o_rx_byte !== exp) begin failures++; $display("FAIL lb_rx_byte: actual=%h required=%h", bus0.o_rx_byte, exp); end
    @(negedge clk);
    checks++; if (bus0.o_rx_dv !== 1'b0) begin failures++; $display("FAIL lb_rx_dv_pulse: actual=%b required=0", bus0.o_rx_dv); end
    checks++; if (dv0_cnt - d0 != 1) begin failures++; $display("FAIL lb_dv_count: actual=%0d required=1", dv0_cnt - d0); end
    checks++; if (rise0 - r0 != 8) begin failures++; $display("FAIL lb_rising_edges: actual=%0d required=8", rise0 - r0); end
    checks++; if (cap0 !== 8'hA5) begin failures++; $display("FAIL lb_mosi_stream: actual=%h required=a5", cap0); end
    checks++; if (sclk0 !== 1'b0) begin failures++; $display("FAIL lb_sclk_idle: actual=%b required=0", sclk0); end
  endtask

  task automatic test_cmd_sequence();
    logic [7:0] tx[3];
    logic [7:0] rsp[3];
    bit ok;
    int acc, d0;
    logic [7:0] exp;
    tx = '{8'h80, 8'h05, 8'h00};
    rsp = '{8'h00, 8'h00, 8'h3C};
    loop0 = 1'b0;
    d0 = dv0_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_ready0(50, ok);
      slave_sr0 = rsp[k];
      sb0.push_back(rsp[k]);
      send0(tx[k], acc);
      @(negedge clk);
      checks++; if (bus0.o_tx_ready !== 1'b0) begin failures++; $display("FAIL cmd_ready_low_b%0d: actual=%b required=0", k, bus0.o_tx_ready); end
      wait_rx0(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL cmd_rx_timeout_b%0d: actual=none required=rx_dv", k); end
      exp = sb0.pop_front();
      checks++; if (bus0.o_rx_byte !== exp) begin failures++; $display("FAIL cmd_rx_byte_b%0d: actual=%h required=%h", k, bus0.o_rx_byte, exp); end
      checks++; if (cap0 !== tx[k]) begin failures++; $display("FAIL cmd_mosi_b%0d: actual=%h required=%h", k, cap0, tx[k]); end
    end
    repeat (2) @(negedge clk);
    checks++; if (dv0_cnt - d0 != 3) begin failures++; $display("FAIL cmd_dv_count: actual=%0d required=3", dv0_cnt - d0); end
  endtask

  task automatic test_ignored_pulses();
    bit ok;
    int acc, r0, d0;
    loop0 = 1'b1;
    wait_ready0(50, ok);
    r0 = rise0; d0 = dv0_cnt;
    sb0.push_back(8'h5A);
    send0(8'h5A, acc);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus0.o_tx_ready === 1'b1) begin ok = 1'b1; break; end
      if ((cyc - acc == 3) || (cyc - acc == 10)) begin
        bus0.i_tx_byte = 8'hFF;
        bus0.i_tx_dv   = 1'b1;
      end else begin
        bus0.i_tx_dv   = 1'b0;
      end
      @(negedge clk);
    end
    bus0.i_tx_dv = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL ign_ready_timeout: actual=0 required=1"); end
    begin
      logic [7:0] exp;
      exp = sb0.pop_front();
      checks++; if (bus0.o_rx_byte !== exp) begin failures++; $display("FAIL ign_rx_byte: actual=%h required=%h", bus0.o_rx_byte, exp); end
    end
    repeat (80) @(negedge clk);
    checks++; if (dv0_cnt - d0 != 1) begin failures++; $display("FAIL ign_dv_count: actual=%0d required=1", dv0_cnt - d0); end
    checks++; if (rise0 - r0 != 8) begin failures++; $display("FAIL ign_rising_edges: actual=%0d required=8", rise0 - r0); end
    checks++; if (cap0 !== 8'h5A) begin failures++; $display("FAIL ign_mosi_stream: actual=%h required=5a", cap0); end
    checks++; if (bus0.o_tx_ready !== 1'b1) begin failures++; $display("FAIL ign_ready_idle: actual=%b required=1", bus0.o_tx_ready); end
  endtask

  task automatic test_reset_midbyte();
    bit ok;
    int acc, r0, d0;
    loop0 = 1'b1;
    wait_ready0(50, ok);
    r0 = rise0; d0 = dv0_cnt;
    send0(8'h33, acc);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rise0 - r0 >= 4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmid_edge7_timeout: actual=%0d required=4", rise0 - r0); end
    rstn = 1'b0;
    #1;
    checks++; if (sclk0 !== 1'b0) begin failures++; $display("FAIL rmid_sclk_cpol: actual=%b required=0", sclk0); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus0.o_tx_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_release: actual=%b required=1", bus0.o_tx_ready); end
    repeat (60) @(negedge clk);
    checks++; if (dv0_cnt != d0) begin failures++; $display("FAIL rmid_no_rx_dv: actual=%0d required=%0d", dv0_cnt, d0); end
    checks++; if (rise0 - r0 != 4) begin failures++; $display("FAIL rmid_no_more_edges: actual=%0d required=4", rise0 - r0); end
  endtask

  task automatic test_mode3();
    bit ok;
    int acc, lat, r1, bad, changes;
    logic prev_m, prev_s;
    logic [7:0] exp;
    wait_ready1(50, ok);
    checks++; if (sclk1 !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle_pre: actual=%b required=1", sclk1); end
    pat1 = 8'hC3; idx1 = 0;
    sb1.push_back(8'hC3);
    r1 = rise1;
    send1(8'h3C, acc);
    prev_m = mosi1; prev_s = sclk1;
    bad = 0; changes = 0; ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (mosi1 !== prev_m) begin
        changes++;
        if (!(prev_s === 1'b1 && sclk1 === 1'b0)) bad++;
      end
      prev_m = mosi1; prev_s = sclk1;
      if (bus1.o_tx_ready === 1'b1) begin ok = 1'b1; break; end
    end
    lat = cyc - acc;
    checks++; if (!ok || lat != 50) begin failures++; $display("FAIL m3_latency: actual=%0d required=50 (ok=%0b)", lat, ok); end
    checks++; if (bad != 0) begin failures++; $display("FAIL m3_mosi_on_fall: actual=%0d required=0", bad); end
    checks++; if (changes != 2) begin failures++; $display("FAIL m3_mosi_changes: actual=%0d required=2", changes); end
    checks++; if (bus1.o_rx_dv !== 1'b1) begin failures++; $display("FAIL m3_rx_dv: actual=%b required=1", bus1.o_rx_dv); end
    exp = sb1.pop_front();
    checks++; if (bus1.o_rx_byte !== exp) begin failures++; $display("FAIL m3_rx_byte: actual=%h required=%h", bus1.o_rx_byte, exp); end
    checks++; if (cap1 !== 8'h3C) begin failures++; $display("FAIL m3_mosi_stream: actual=%h required=3c", cap1); end
    checks++; if (rise1 - r1 != 8) begin failures++; $display("FAIL m3_rising_edges: actual=%0d required=8", rise1 - r1); end
    checks++; if (sclk1 !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle_post: actual=%b required=1", sclk1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc1, acc2, first;
    logic [7:0] exp;
    loop0 = 1'b1;
    wait_ready0(50, ok);
    sb0.push_back(8'h96);
    send0(8'h96, acc1);
    wait_ready0(100, ok);
    checks++; if (!ok || bus0.o_rx_dv !== 1'b1) begin failures++; $display("FAIL b2b_done_cycle: actual=%b required=1 (ok=%0b)", bus0.o_rx_dv, ok); end
    exp = sb0.pop_front();
    checks++; if (bus0.o_rx_byte !== exp) begin failures++; $display("FAIL b2b_rx_byte1: actual=%h required=%h", bus0.o_rx_byte, exp); end
    sb0.push_back(8'h69);
    send0(8'h69, acc2);
    checks++; if (bus0.o_tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_accepted: actual=%b required=0", bus0.o_tx_ready); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sclk0 === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    first = cyc - acc2;
    checks++; if (!ok || first != 3) begin failures++; $display("FAIL b2b_first_edge: actual=%0d required=3 (ok=%0b)", first, ok); end
    wait_rx0(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_rx_timeout: actual=none required=rx_dv"); end
    exp = sb0.pop_front();
    checks++; if (bus0.o_rx_byte !== exp) begin failures++; $display("FAIL b2b_rx_byte2: actual=%h required=%h", bus0.o_rx_byte, exp); end
    checks++; if (cap0 !== 8'h69) begin failures++; $display("FAIL b2b_mosi_stream: actual=%h required=69", cap0); end
  endtask

  initial begin
    bus0.i_tx_byte = '0; bus0.i_tx_dv = 1'b0;
    bus1.i_tx_byte = '0; bus1.i_tx_dv = 1'b0;
    test_reset();
    test_loopback();
    test_cmd_sequence();
    test_ignored_pulses();
    test_reset_midbyte();
    test_mode3();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
